// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//
// MEM/WB pipeline stage of the 5-stage forwarding pipeline, directly upstream
// of the register file. Non-load results are registered for one cycle. For a
// load, the stage stalls EX/MEM and waits a variable number of cycles for the
// data-memory response. It then extends the addressed byte or half-word and
// registers it. All write-side outputs are functions of registers only, so
// they are stable for the whole cycle. The RF samples them on negedge.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   in_*            EX/MEM instruction fields (valid, regwrite, memtoreg,
//                   jal, ld_type, byte_off, wa, alu, pcadd4)
//   dm_rvalid/rdata data-memory load response (single-cycle pulse)
//   stall_o         upstream must hold EX/MEM (high while a load is pending)
//   rf_we/wa/wd     register-file write port
//   rf_31we/pcadd4  link ($31) write port
//   fwd_*           WB forwarding bus (mirrors the RF write port)
//   misalign_o      sticky: a misaligned load has completed
//   spurious_o      sticky: dm_rvalid arrived with no load pending
//
// Assumes DATA_W >= 32, because the load lanes are 32-bit word lanes.
// ---------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_regwrite,
  input  logic              in_memtoreg,
  input  logic              in_jal,
  input  logic [2:0]        in_ld_type,
  input  logic [1:0]        in_byte_off,
  input  logic [REG_AW-1:0] in_wa,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_pcadd4,
  input  logic              dm_rvalid,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              stall_o,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              rf_31we,
  output logic [DATA_W-1:0] rf_pcadd4,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic              misalign_o,
  output logic              spurious_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  localparam logic [REG_AW-1:0] LINK_REG = REG_AW'(31);

  state_t             state_reg;
  logic               wb_v_reg;
  logic               wb_regwrite_reg;
  logic               wb_jal_reg;
  logic [REG_AW-1:0]  wb_wa_reg;
  logic [DATA_W-1:0]  wb_wd_reg;
  logic [DATA_W-1:0]  wb_pcadd4_reg;
  logic               wb_misalign_reg;
  logic [2:0]         ld_type_reg;
  logic [1:0]         ld_off_reg;
  logic               misalign_reg;
  logic               spurious_reg;

  // Load extraction uses the lane captured at accept time, because the
  // EX/MEM fields may already belong to the next instruction.
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [DATA_W-1:0]  ld_data;
  logic               ld_misaligned;

  always_comb begin
    byte_sel      = dm_rdata[7:0];
    half_sel      = ld_off_reg[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    ld_data       = dm_rdata;
    ld_misaligned = 1'b0;
    case (ld_off_reg)
      2'd0:    byte_sel = dm_rdata[7:0];
      2'd1:    byte_sel = dm_rdata[15:8];
      2'd2:    byte_sel = dm_rdata[23:16];
      default: byte_sel = dm_rdata[31:24];
    endcase
    case (ld_type_reg)
      LD_LB:  ld_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LD_LBU: ld_data = {{(DATA_W-8){1'b0}}, byte_sel};
      LD_LH: begin
        ld_data       = {{(DATA_W-16){half_sel[15]}}, half_sel};
        ld_misaligned = ld_off_reg[0];
      end
      LD_LHU: begin
        ld_data       = {{(DATA_W-16){1'b0}}, half_sel};
        ld_misaligned = ld_off_reg[0];
      end
      default: begin
        // LW. Reserved encodings are also treated as a full-word load.
        ld_data       = dm_rdata;
        ld_misaligned = (ld_off_reg != 2'd0);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      wb_v_reg        <= 1'b0;
      wb_regwrite_reg <= 1'b0;
      wb_jal_reg      <= 1'b0;
      wb_wa_reg       <= '0;
      wb_wd_reg       <= '0;
      wb_pcadd4_reg   <= '0;
      wb_misalign_reg <= 1'b0;
      ld_type_reg     <= LD_LW;
      ld_off_reg      <= 2'd0;
      misalign_reg    <= 1'b0;
      spurious_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (dm_rvalid) begin
            spurious_reg <= 1'b1;
          end
          // stall_o is low in IDLE, so in_valid alone means accept.
          if (in_valid) begin
            wb_regwrite_reg <= in_regwrite;
            wb_jal_reg      <= in_jal;
            wb_wa_reg       <= in_wa;
            wb_pcadd4_reg   <= in_pcadd4;
            if (in_memtoreg) begin
              ld_type_reg <= in_ld_type;
              ld_off_reg  <= in_byte_off;
              wb_v_reg    <= 1'b0;
              state_reg   <= ST_WAIT;
            end else begin
              wb_wd_reg       <= in_alu;
              wb_misalign_reg <= 1'b0;
              wb_v_reg        <= 1'b1;
            end
          end else begin
            wb_v_reg <= 1'b0;
          end
        end
        default: begin
          if (dm_rvalid) begin
            wb_wd_reg       <= ld_data;
            wb_misalign_reg <= ld_misaligned;
            if (ld_misaligned) begin
              misalign_reg <= 1'b1;
            end
            wb_v_reg  <= 1'b1;
            state_reg <= ST_IDLE;
          end else begin
            wb_v_reg <= 1'b0;
          end
        end
      endcase
    end
  end

  logic link_we;
  logic reg_we;

  assign link_we = wb_v_reg & wb_jal_reg;
  // $31 has a single writer. A JAL that also names $31 as rd writes
  // through the link port only.
  assign reg_we  = wb_v_reg & wb_regwrite_reg & (wb_wa_reg != '0) & ~wb_misalign_reg
                 & ~(link_we & (wb_wa_reg == LINK_REG));

  assign stall_o    = (state_reg == ST_WAIT);
  assign rf_we      = reg_we;
  assign rf_wa      = wb_wa_reg;
  assign rf_wd      = wb_wd_reg;
  assign rf_31we    = link_we;
  assign rf_pcadd4  = wb_pcadd4_reg;
  assign fwd_valid  = reg_we;
  assign fwd_addr   = wb_wa_reg;
  assign fwd_data   = wb_wd_reg;
  assign misalign_o = misalign_reg;
  assign spurious_o = spurious_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_regwrite, in_memtoreg, in_jal;
  logic [2:0]  in_ld_type;
  logic [1:0]  in_byte_off;
  logic [4:0]  in_wa;
  logic [31:0] in_alu, in_pcadd4;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        stall_o, rf_we, rf_31we, fwd_valid, misalign_o, spurious_o;
  logic [4:0]  rf_wa, fwd_addr;
  logic [31:0] rf_wd, rf_pcadd4, fwd_data;

  int n_checks = 0;
  int n_errors = 0;
  int txn = 0;
  logic exp_mis = 1'b0;
  logic exp_spur = 1'b0;

  mem_wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
    .in_jal(in_jal), .in_ld_type(in_ld_type), .in_byte_off(in_byte_off),
    .in_wa(in_wa), .in_alu(in_alu), .in_pcadd4(in_pcadd4),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .stall_o(stall_o), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .rf_31we(rf_31we), .rf_pcadd4(rf_pcadd4),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .misalign_o(misalign_o), .spurious_o(spurious_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Loaded value derived from the load rules with plain arithmetic.
  function automatic logic [31:0] load_val(input int t, input int off, input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (t)
      1:       return (b >= 128) ? b + 32'hFFFFFF00 : b;
      2:       return b;
      3:       return (h >= 32768) ? h + 32'hFFFF0000 : h;
      4:       return h;
      default: return w;
    endcase
  endfunction

  function automatic logic is_mis(input int t, input int off);
    if (t == 3 || t == 4) return (off % 2) != 0;
    if (t == 0) return off != 0;
    return 1'b0;
  endfunction

  task automatic chk_wb(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic lwe, input logic [31:0] pc);
    chk("rf_we", 32'(rf_we), 32'(we));
    chk("fwd_valid", 32'(fwd_valid), 32'(we));
    if (we) begin
      chk("rf_wa", 32'(rf_wa), 32'(wa));
      chk("rf_wd", rf_wd, wd);
      chk("fwd_addr", 32'(fwd_addr), 32'(wa));
      chk("fwd_data", fwd_data, wd);
    end
    chk("rf_31we", 32'(rf_31we), 32'(lwe));
    if (lwe) chk("rf_pcadd4", rf_pcadd4, pc);
    chk("stall_o", 32'(stall_o), 32'd0);
    chk("misalign_o", 32'(misalign_o), 32'(exp_mis));
    chk("spurious_o", 32'(spurious_o), 32'(exp_spur));
  endtask

  // Called at a negedge. Drives one instruction, then waits for its write-back
  // and checks it. Returns at a negedge with in_valid low.
  task automatic run_instr(input logic rw, input logic mem, input logic jal,
                           input int t, input int off, input logic [4:0] wa,
                           input logic [31:0] alu, input logic [31:0] pc,
                           input int lat, input logic [31:0] rdata);
    logic mis;
    logic we;
    logic [31:0] wd;
    in_valid = 1'b1; in_regwrite = rw; in_memtoreg = mem; in_jal = jal;
    in_ld_type = 3'(t); in_byte_off = 2'(off); in_wa = wa; in_alu = alu; in_pcadd4 = pc;
    mis = mem ? is_mis(t, off) : 1'b0;
    wd  = mem ? load_val(t, off, rdata) : alu;
    we  = rw && (wa != 5'd0) && !mis && !(jal && wa == 5'd31);
    if (mem) begin
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        in_valid = 1'b0;
        chk("wait_stall", 32'(stall_o), 32'd1);
        chk("wait_rf_we", 32'(rf_we), 32'd0);
        if (i == lat - 1) begin
          dm_rvalid = 1'b1;
          dm_rdata  = rdata;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    dm_rvalid = 1'b0;
    if (mis) exp_mis = 1'b1;
    chk_wb(we, wa, wd, jal, pc);
    txn++;
    $display("txn %0d: mem=%0d t=%0d off=%0d wa=%0d lat=%0d -> we=%0d wd=%h 31we=%0d",
             txn, mem, t, off, wa, lat, rf_we, rf_wd, rf_31we);
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_regwrite = 0; in_memtoreg = 0; in_jal = 0;
    in_ld_type = 0; in_byte_off = 0; in_wa = 0; in_alu = 0; in_pcadd4 = 0;
    dm_rvalid = 0; dm_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_31we", 32'(rf_31we), 32'd0);
    chk("rst_rf_wd", rf_wd, 32'd0);
    chk("rst_rf_wa", 32'(rf_wa), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_misalign", 32'(misalign_o), 32'd0);
    chk("rst_spurious", 32'(spurious_o), 32'd0);
    rst = 1'b0;

    // Directed cases
    run_instr(1, 0, 0, 0, 0, 5'd5, 32'h1234, 32'h0, 0, 32'h0);               // ADD r5
    run_instr(1, 1, 0, 1, 2, 5'd7, 32'h0, 32'h0, 3, 32'h00800000);           // LB off2
    run_instr(1, 1, 0, 4, 2, 5'd8, 32'h0, 32'h0, 1, 32'hBEEF0000);           // LHU off2
    run_instr(1, 1, 0, 3, 1, 5'd9, 32'h0, 32'h0, 2, 32'h12345678);           // LH off1 misaligned
    run_instr(1, 0, 0, 0, 0, 5'd0, 32'hDEAD, 32'h0, 0, 32'h0);               // write r0
    run_instr(1, 0, 1, 0, 0, 5'd31, 32'h55, 32'h40, 0, 32'h0);               // JAL
    run_instr(1, 1, 0, 0, 0, 5'd10, 32'h0, 32'h0, 2, 32'hCAFEF00D);          // LW aligned
    run_instr(1, 1, 0, 2, 3, 5'd11, 32'h0, 32'h0, 1, 32'h9A000000);          // LBU off3

    // Back-to-back non-loads: one write per cycle, no bubble
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_regwrite = 1; in_memtoreg = 0; in_jal = 0;
      in_wa = 5'(12 + k); in_alu = 32'h100 + 32'(k);
      @(negedge clk);
      chk("b2b_we", 32'(rf_we), 32'd1);
      chk("b2b_wa", 32'(rf_wa), 32'(12 + k));
      chk("b2b_wd", rf_wd, 32'h100 + 32'(k));
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_idle_we", 32'(rf_we), 32'd0);

    // Randomized instructions against the model
    for (int n = 0; n < 60; n++) begin
      logic mem;
      logic jal;
      logic [4:0] wa;
      mem = ($urandom_range(0, 9) < 4);
      jal = !mem && ($urandom_range(0, 4) == 0);
      wa  = ($urandom_range(0, 7) == 0) ? 5'd0 : (($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom));
      run_instr(1'($urandom_range(0, 5) != 0), mem, jal, $urandom_range(0, 4),
                $urandom_range(0, 3), wa, $urandom, $urandom,
                $urandom_range(1, 4), $urandom);
    end

    // Reset in the middle of a pending load, then a late response
    in_valid = 1'b1; in_regwrite = 1; in_memtoreg = 1; in_jal = 0;
    in_ld_type = 3'd1; in_byte_off = 2'd0; in_wa = 5'd20;
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_stall_pre", 32'(stall_o), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_mis = 1'b0;
    chk("abort_stall", 32'(stall_o), 32'd0);
    chk("abort_rf_we", 32'(rf_we), 32'd0);
    chk("abort_misalign", 32'(misalign_o), 32'd0);
    chk("abort_spurious_pre", 32'(spurious_o), 32'd0);
    dm_rvalid = 1'b1; dm_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    dm_rvalid = 1'b0;
    exp_spur = 1'b1;
    chk_wb(1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("late_rf_we", 32'(rf_we), 32'd0);
    chk("spurious_sticky", 32'(spurious_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
